// File: rtl/euler_defs.sv
// Shared definitions for the Euler integrator control path.
// Holds the sequencer state encodings and the default datapath widths; the
// Euler start FSM imports the same package so both agree on the encoding.
package euler_defs;

  localparam int unsigned StepWDefault = 16;  // step count / step index width
  localparam int unsigned LatWDefault  = 8;   // compute-timeout limit width

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] StIdle  = 3'd0;
  localparam logic [StateW-1:0] StIssue = 3'd1;
  localparam logic [StateW-1:0] StWait  = 3'd2;
  localparam logic [StateW-1:0] StWrite = 3'd3;
  localparam logic [StateW-1:0] StDone  = 3'd4;

endpackage

// File: rtl/euler_wdt_counter.sv
// Compute-timeout watchdog for the Euler step sequencer.
// Counts enabled cycles since the last clear. expired is asserted in the
// cycle whose increment would make the count equal a nonzero limit, so the
// owner can leave its wait state on that same edge.
// Ports:
//   clk       - clock, state updates on the falling edge
//   rst_async - asynchronous active-high reset
//   rst_sync  - synchronous active-high reset
//   clear     - zero the count (wins over enable)
//   enable    - count this cycle
//   limit     - timeout limit in cycles, 0 disables expiry
//   expired   - limit reached this cycle
module euler_wdt_counter
  import euler_defs::*;
#(
  parameter int unsigned LAT_W = LatWDefault
) (
  input  logic             clk,
  input  logic             rst_async,
  input  logic             rst_sync,
  input  logic             clear,
  input  logic             enable,
  input  logic [LAT_W-1:0] limit,
  output logic             expired
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    expired = enable && (limit != '0) && (cnt_d == limit);
  end

  always_ff @(negedge clk or posedge rst_async) begin
    if (rst_async) begin
      cnt_q <= '0;
    end else if (rst_sync || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/euler_step_sequencer.sv
// Euler step sequencer: runs num_steps step computations on the arithmetic
// unit, each as ISSUE (unit_go pulse) -> WAIT (for unit_done) -> WRITE
// (x_we pulse), then reports completion with a one-cycle final_done.
// All outputs are registered and change on the same falling edge as the state.
// Ports:
//   clk          - clock, all state updates on the falling edge
//   rst_async    - asynchronous active-high reset
//   rst_sync     - synchronous active-high reset
//   start        - start pulse, honoured only in IDLE
//   num_steps    - step count, latched at start
//   calc_timeout - per-step wait limit in cycles (0 = none), latched at start
//   unit_done    - arithmetic unit result ready
//   unit_err     - arithmetic unit error, looked at only while waiting
//   unit_go      - launch one step computation
//   x_we         - state-vector write-back enable
//   step_idx     - index of the current step
//   busy         - run in progress, through the final_done cycle
//   final_done   - completion pulse
//   err          - sticky error, cleared by the next accepted start
module euler_step_sequencer
  import euler_defs::*;
#(
  parameter int unsigned STEP_W = StepWDefault,
  parameter int unsigned LAT_W  = LatWDefault
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              rst_sync,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [LAT_W-1:0]  calc_timeout,
  input  logic              unit_done,
  input  logic              unit_err,
  output logic              unit_go,
  output logic              x_we,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              final_done,
  output logic              err
);

  logic [StateW-1:0] state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [LAT_W-1:0]  timeout_q, timeout_d;
  logic [STEP_W-1:0] step_idx_q, step_idx_d;
  logic              unit_go_q, unit_go_d;
  logic              x_we_q, x_we_d;
  logic              busy_q, busy_d;
  logic              final_done_q, final_done_d;
  logic              err_q, err_d;

  logic wdt_clear;
  logic wdt_enable;
  logic wdt_expired;

  // The counter is zeroed while the step is being issued and runs only while
  // waiting for the result.
  assign wdt_clear  = (state_q == StIssue);
  assign wdt_enable = (state_q == StWait);

  euler_wdt_counter #(
    .LAT_W(LAT_W)
  ) u_wdt (
    .clk      (clk),
    .rst_async(rst_async),
    .rst_sync (rst_sync),
    .clear    (wdt_clear),
    .enable   (wdt_enable),
    .limit    (timeout_q),
    .expired  (wdt_expired)
  );

  // Pulse outputs are set on the transition into the state that owns them,
  // so they are registered yet aligned with that state.
  always_comb begin
    state_d      = state_q;
    steps_d      = steps_q;
    timeout_d    = timeout_q;
    step_idx_d   = step_idx_q;
    busy_d       = busy_q;
    err_d        = err_q;
    unit_go_d    = 1'b0;
    x_we_d       = 1'b0;
    final_done_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          steps_d    = num_steps;
          timeout_d  = calc_timeout;
          step_idx_d = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          if (num_steps == '0) begin
            state_d      = StDone;
            final_done_d = 1'b1;
          end else begin
            state_d   = StIssue;
            unit_go_d = 1'b1;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        // A result in the same cycle as an error or timeout still counts.
        if (unit_done) begin
          state_d = StWrite;
          x_we_d  = 1'b1;
        end else if (unit_err || wdt_expired) begin
          err_d        = 1'b1;
          state_d      = StDone;
          final_done_d = 1'b1;
        end
      end
      StWrite: begin
        // Compare against the last index rather than incrementing first, so
        // an all-ones step count finishes without step_idx wrapping.
        if (step_idx_q == steps_q - 1'b1) begin
          state_d      = StDone;
          final_done_d = 1'b1;
        end else begin
          step_idx_d = step_idx_q + 1'b1;
          state_d    = StIssue;
          unit_go_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q      <= StIdle;
      steps_q      <= '0;
      timeout_q    <= '0;
      step_idx_q   <= '0;
      unit_go_q    <= 1'b0;
      x_we_q       <= 1'b0;
      busy_q       <= 1'b0;
      final_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else if (rst_sync) begin
      state_q      <= StIdle;
      steps_q      <= '0;
      timeout_q    <= '0;
      step_idx_q   <= '0;
      unit_go_q    <= 1'b0;
      x_we_q       <= 1'b0;
      busy_q       <= 1'b0;
      final_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_q      <= steps_d;
      timeout_q    <= timeout_d;
      step_idx_q   <= step_idx_d;
      unit_go_q    <= unit_go_d;
      x_we_q       <= x_we_d;
      busy_q       <= busy_d;
      final_done_q <= final_done_d;
      err_q        <= err_d;
    end
  end

  assign unit_go    = unit_go_q;
  assign x_we       = x_we_q;
  assign step_idx   = step_idx_q;
  assign busy       = busy_q;
  assign final_done = final_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_euler_step_sequencer.sv
// Self-checking bench for euler_step_sequencer. The DUT switches on the
// falling edge; the bench drives inputs 1 ns after the falling edge and the
// monitor samples on the rising edge. Expected write-back indices go into a
// queue at stimulus time and are popped as x_we pulses appear.
module tb_euler_step_sequencer;

  localparam int unsigned STEP_W = 4;
  localparam int unsigned LAT_W  = 8;

  logic              clk;
  logic              rst_async;
  logic              rst_sync;
  logic              start;
  logic [STEP_W-1:0] num_steps;
  logic [LAT_W-1:0]  calc_timeout;
  logic              unit_done;
  logic              unit_err;
  logic              unit_go;
  logic              x_we;
  logic [STEP_W-1:0] step_idx;
  logic              busy;
  logic              final_done;
  logic              err;

  euler_step_sequencer #(
    .STEP_W(STEP_W),
    .LAT_W (LAT_W)
  ) dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .rst_sync    (rst_sync),
    .start       (start),
    .num_steps   (num_steps),
    .calc_timeout(calc_timeout),
    .unit_done   (unit_done),
    .unit_err    (unit_err),
    .unit_go     (unit_go),
    .x_we        (x_we),
    .step_idx    (step_idx),
    .busy        (busy),
    .final_done  (final_done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected step_idx values at each x_we.
  int exp_we_q[$];

  // Monitor state, written only by the monitor process.
  int cyc       = 0;
  int go_cnt    = 0;
  int we_cnt    = 0;
  int fd_cnt    = 0;
  int go_cyc    = 0;
  int fd_cyc    = 0;
  int start_cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (start) start_cyc = cyc;
      if (unit_go) begin
        go_cnt++;
        go_cyc = cyc;
      end
      if (x_we) begin
        we_cnt++;
        if (exp_we_q.size() > 0) check_eq("we_idx", 32'(step_idx), exp_we_q.pop_front());
        else check_eq("we_unexpected", 32'(x_we), 0);
      end
      if (final_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  // Arithmetic unit model: reacts done_dly cycles after unit_go.
  // resp_mode 0: unit_done, 1: unit_done with unit_err, 2: unit_err only.
  int resp_mode = 0;
  int done_dly  = 2;
  bit done_en   = 1'b1;

  initial begin
    int cnt;
    cnt       = 0;
    unit_done = 1'b0;
    unit_err  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      unit_done = 1'b0;
      unit_err  = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          case (resp_mode)
            0: unit_done = 1'b1;
            1: begin
              unit_done = 1'b1;
              unit_err  = 1'b1;
            end
            default: unit_err = 1'b1;
          endcase
        end
      end
      if (unit_go && done_en) cnt = done_dly;
    end
  end

  int go0, we0, fd0;

  task automatic snap();
    go0 = go_cnt;
    we0 = we_cnt;
    fd0 = fd_cnt;
  endtask

  task automatic start_run(input int n, input int to);
    num_steps    = n[STEP_W-1:0];
    calc_timeout = to[LAT_W-1:0];
    start        = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_fd(input int bound, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (final_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_fd_seen"}, 32'(seen), 1);
    @(negedge clk);
    #1;
  endtask

  // sel 0: unit_go, sel 1: x_we
  task automatic wait_out(input int sel, input int bound, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if ((sel == 0) ? unit_go : x_we) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_seen"}, 32'(seen), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start        = 1'b0;
    num_steps    = '0;
    calc_timeout = '0;
    rst_sync     = 1'b0;
    rst_async    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_go", 32'(unit_go), 0);
    check_eq("rst_we", 32'(x_we), 0);
    check_eq("rst_fd", 32'(final_done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_idx", 32'(step_idx), 0);
    rst_async = 1'b0;
    @(negedge clk);
    #1;

    // Three steps, result two cycles after each launch.
    snap();
    done_dly = 2;
    for (int i = 0; i < 3; i++) exp_we_q.push_back(i);
    start_run(3, 0);
    check_eq("t1_busy", 32'(busy), 1);
    wait_fd(100, "t1");
    check_eq("t1_go", 32'(go_cnt - go0), 3);
    check_eq("t1_we", 32'(we_cnt - we0), 3);
    check_eq("t1_fd", 32'(fd_cnt - fd0), 1);
    check_eq("t1_err", 32'(err), 0);
    check_eq("t1_busy_end", 32'(busy), 0);

    // Zero steps: completion on the next cycle, nothing launched.
    snap();
    start_run(0, 0);
    wait_fd(10, "t2");
    check_eq("t2_go", 32'(go_cnt - go0), 0);
    check_eq("t2_we", 32'(we_cnt - we0), 0);
    check_eq("t2_fd", 32'(fd_cnt - fd0), 1);
    check_eq("t2_lat", 32'(fd_cyc - start_cyc), 1);

    // Timeout of 4 with no result.
    snap();
    done_en = 1'b0;
    start_run(2, 4);
    wait_fd(50, "t3");
    check_eq("t3_err", 32'(err), 1);
    check_eq("t3_go", 32'(go_cnt - go0), 1);
    check_eq("t3_we", 32'(we_cnt - we0), 0);
    check_eq("t3_lat", 32'(fd_cyc - go_cyc), 5);
    done_en = 1'b1;

    // Result and error together: result wins; start also clears old err.
    snap();
    resp_mode = 1;
    exp_we_q.push_back(0);
    start_run(1, 0);
    check_eq("t4_err_clr", 32'(err), 0);
    wait_fd(50, "t4");
    check_eq("t4_err", 32'(err), 0);
    check_eq("t4_we", 32'(we_cnt - we0), 1);

    // Error alone aborts the run.
    snap();
    resp_mode = 2;
    start_run(2, 0);
    wait_fd(50, "t5");
    check_eq("t5_err", 32'(err), 1);
    check_eq("t5_we", 32'(we_cnt - we0), 0);
    check_eq("t5_go", 32'(go_cnt - go0), 1);
    resp_mode = 0;

    // Start re-pulsed while waiting must be ignored (its 1-cycle timeout too).
    snap();
    done_dly = 4;
    for (int i = 0; i < 3; i++) exp_we_q.push_back(i);
    start_run(3, 0);
    wait_out(0, 10, "t6_go");
    @(negedge clk);
    #1;
    num_steps    = 4'd9;
    calc_timeout = 8'd1;
    start        = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_fd(100, "t6");
    check_eq("t6_we", 32'(we_cnt - we0), 3);
    check_eq("t6_go", 32'(go_cnt - go0), 3);
    check_eq("t6_err", 32'(err), 0);

    // All-ones step count runs the full range without wrapping.
    snap();
    done_dly = 1;
    for (int i = 0; i < 15; i++) exp_we_q.push_back(i);
    start_run(15, 0);
    wait_fd(300, "t7");
    check_eq("t7_we", 32'(we_cnt - we0), 15);
    check_eq("t7_fd", 32'(fd_cnt - fd0), 1);
    check_eq("t7_err", 32'(err), 0);
    check_eq("t7_sb_empty", 32'(exp_we_q.size()), 0);

    // Asynchronous reset while waiting on step 2 of 5.
    snap();
    done_dly = 2;
    exp_we_q.push_back(0);
    start_run(5, 0);
    wait_out(1, 20, "t8_we");
    @(negedge clk);
    #1;
    wait_out(0, 20, "t8_go");
    @(negedge clk);
    #1;
    rst_async = 1'b1;
    #1;
    check_eq("t8_busy", 32'(busy), 0);
    check_eq("t8_idx", 32'(step_idx), 0);
    check_eq("t8_go_low", 32'(unit_go), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_async = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_eq("t8_fd", 32'(fd_cnt - fd0), 0);
    check_eq("t8_we", 32'(we_cnt - we0), 1);
    check_eq("t8_busy_after", 32'(busy), 0);

    // Synchronous reset while waiting.
    snap();
    start_run(2, 0);
    wait_out(0, 10, "t9_go");
    @(negedge clk);
    #1;
    rst_sync = 1'b1;
    @(negedge clk);
    #1;
    check_eq("t9_busy", 32'(busy), 0);
    check_eq("t9_idx", 32'(step_idx), 0);
    rst_sync = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_eq("t9_fd", 32'(fd_cnt - fd0), 0);
    check_eq("t9_we", 32'(we_cnt - we0), 0);
    check_eq("sb_empty", 32'(exp_we_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
